fifo_pkt_reader: RTL

// - Downstream drain stage for the first-word-fall-through fifo: pops words, frames them into fixed-length packets.
// - Emits packets on a registered valid/ready stream with m_last on the final beat.
// - Pads a stalled partial packet with PAD_VALUE after a timeout so packets never stay open.

---
 rtl/fifo_pkt_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: drains a first-word-fall-through fifo into fixed-length
// packets on a registered valid/ready stream. A packet left open by an empty
// fifo is finished with PAD_VALUE beats once TIMEOUT empty cycles pass.
// Optional build macro PKT_READER_STATS_EN adds packet and pad beat counters.
module fifo_pkt_reader #(
    parameter int DATA_BITS = 10,
    parameter int PKT_LEN   = 8,
    parameter int TIMEOUT   = 16,
    parameter int PAD_VALUE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_read,
`ifdef PKT_READER_STATS_EN
    output logic [15:0]          pkt_done_count,
    output logic [15:0]          pad_count,
`endif
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last
);

    localparam int BW = $clog2(PKT_LEN);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] PAD    = 2'd2;

    localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] to_cnt;
    logic          slot_free;
    logic          in_pad;
    logic          load;
    logic          last_load;

    // Load whenever the output slot is free and there is something to send;
    // in PAD the beat is synthesized, so the fifo is left untouched.
    always_comb begin
        slot_free = !m_valid || m_ready;
        in_pad    = (state == PAD);
        load      = slot_free && (in_pad || !fifo_empty);
        last_load = load && (beat_cnt == LAST_BEAT);
        fifo_read = load && !in_pad && !reset;
    end

    // Output register and beat position; holds steady while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_last   <= 1'b0;
            beat_cnt <= '0;
        end else if (load) begin
            m_valid  <= 1'b1;
            m_data   <= in_pad ? DATA_BITS'(PAD_VALUE) : fifo_data;
            m_last   <= (beat_cnt == LAST_BEAT);
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end else if (m_ready) begin
            m_valid  <= 1'b0;
        end
    end

    // Packet framing FSM with the empty-fifo timeout that forces padding.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            to_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (load) state <= ACTIVE;
                end
                ACTIVE: begin
                    if (last_load) begin
                        state  <= IDLE;
                        to_cnt <= '0;
                    end else if (load) begin
                        to_cnt <= '0;
                    end else if (fifo_empty) begin
                        // A word arriving right after expiry waits for the next packet.
                        if (to_cnt == TO_MAX) begin
                            state  <= PAD;
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                PAD: begin
                    to_cnt <= '0;
                    if (last_load) state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    to_cnt <= '0;
                end
            endcase
        end
    end

`ifdef PKT_READER_STATS_EN
    logic beat_is_pad;
    logic hs;

    assign hs = m_valid && m_ready;

    // Tag each loaded beat so pad beats can be counted at handshake time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     beat_is_pad <= 1'b0;
        else if (load) beat_is_pad <= in_pad;
    end

    // Saturating counters of completed packets and delivered pad beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_done_count <= '0;
            pad_count      <= '0;
        end else begin
            if (hs && m_last && pkt_done_count != 16'hFFFF)
                pkt_done_count <= pkt_done_count + 16'd1;
            if (hs && beat_is_pad && pad_count != 16'hFFFF)
                pad_count <= pad_count + 16'd1;
        end
    end
`else
    // Statistics counters compiled out.
`endif

endmodule
